// File: rtl/rv32i_exec_mem_unit_if.sv
// rv32i_exec_mem_unit_if: execute/memory bus (decode inputs, init/debug ports, control and data outputs); master drives inputs, slave is the unit
interface rv32i_exec_mem_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;
  logic [DATA_WIDTH-1:0] imm;
  logic init_done;
  logic [ADDR_WIDTH-1:0] init_w_addr;
  logic [DATA_WIDTH-1:0] init_w_dat;
  logic init_w_enb;
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic branch;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;
  logic alu_src;
  logic mem_read;
  logic mem_write;
  logic mem_2_reg;
  logic reg_write;
  logic [1:0] wrt_back_src;
  logic second_u_type_add_src;
  logic [DATA_WIDTH-1:0] alu_results;
  logic alu_zero;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] debug_data;
  modport master (
    output opcode, func3, func7, rs1, rs2, imm, init_done, init_w_addr, init_w_dat, init_w_enb, debug_addr,
    input branch, imm_src, alu_ctrl, alu_src, mem_read, mem_write, mem_2_reg, reg_write, wrt_back_src,
    input second_u_type_add_src, alu_results, alu_zero, mem_rdata, debug_data
  );
  modport slave (
    input opcode, func3, func7, rs1, rs2, imm, init_done, init_w_addr, init_w_dat, init_w_enb, debug_addr,
    output branch, imm_src, alu_ctrl, alu_src, mem_read, mem_write, mem_2_reg, reg_write, wrt_back_src,
    output second_u_type_add_src, alu_results, alu_zero, mem_rdata, debug_data
  );
endinterface

// File: rtl/rv32i_exec_mem_unit.sv
// rv32i_exec_mem_unit: rv32i decoder + ALU + word-addressed data BRAM; ports clk, rst (sync, active-high) and bus (slave: decode/operands/init/debug in, controls/results/load data out)
module rv32i_exec_mem_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input logic clk,
  input logic rst,
  rv32i_exec_mem_unit_if.slave bus
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
    OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
    SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;
  logic [3:0] f3_op, br_op, alu_ctrl;
  logic [2:0] imm_src;
  logic [1:0] wb;
  logic alu_src, mem_read, mem_write, mem_2_reg, reg_write, u_sel, jump, is_br, br_take;
  logic [DATA_WIDTH-1:0] b, res;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  always_comb begin
    f3_op = ADD;
    case (bus.func3)
      3'b000: f3_op = (bus.opcode == OP_R && bus.func7[5]) ? SUB : ADD;
      3'b001: f3_op = SLL;
      3'b010: f3_op = SLT;
      3'b011: f3_op = SLTU;
      3'b100: f3_op = XOR;
      3'b101: f3_op = bus.func7[5] ? SRA : SRL;
      3'b110: f3_op = OR;
      default: f3_op = AND;
    endcase
  end
  // BEQ/BNE compare by subtraction; signed/unsigned ordering compares use SLT/SLTU
  assign br_op = bus.func3[2] ? (bus.func3[1] ? SLTU : SLT) : SUB;
  // LT variants take the branch on a non-zero SLT result, GE variants on zero
  assign br_take = bus.func3 == 3'b000 ? bus.alu_zero :
                   bus.func3 == 3'b001 ? !bus.alu_zero :
                   bus.func3[2] ? (bus.func3[0] ? bus.alu_zero : !bus.alu_zero) : 1'b0;
  always_comb begin
    imm_src = 3'b000;
    alu_ctrl = ADD;
    alu_src = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_2_reg = 1'b0;
    reg_write = 1'b0;
    wb = 2'b00;
    u_sel = 1'b0;
    jump = 1'b0;
    is_br = 1'b0;
    if (!rst)
      case (bus.opcode)
        OP_R: begin
          alu_ctrl = f3_op;
          wb = 2'b01;
          reg_write = 1'b1;
        end
        OP_I: begin
          alu_ctrl = f3_op;
          alu_src = 1'b1;
          wb = 2'b01;
          reg_write = 1'b1;
        end
        OP_LOAD: begin
          alu_src = 1'b1;
          mem_read = 1'b1;
          mem_2_reg = 1'b1;
          reg_write = 1'b1;
        end
        OP_STORE: begin
          imm_src = 3'b001;
          alu_src = 1'b1;
          mem_write = 1'b1;
        end
        OP_BR: begin
          imm_src = 3'b010;
          alu_ctrl = br_op;
          is_br = 1'b1;
        end
        OP_JAL: begin
          imm_src = 3'b100;
          jump = 1'b1;
          wb = 2'b10;
          reg_write = 1'b1;
        end
        OP_JALR: begin
          alu_src = 1'b1;
          jump = 1'b1;
          wb = 2'b10;
          reg_write = 1'b1;
        end
        OP_LUI: begin
          imm_src = 3'b011;
          wb = 2'b11;
          u_sel = 1'b1;
          reg_write = 1'b1;
        end
        OP_AUIPC: begin
          imm_src = 3'b011;
          wb = 2'b11;
          reg_write = 1'b1;
        end
        default: ;
      endcase
  end
  assign b = alu_src ? bus.imm : bus.rs2;
  always_comb begin
    res = '0;
    case (alu_ctrl)
      ADD: res = bus.rs1 + b;
      SUB: res = bus.rs1 - b;
      AND: res = bus.rs1 & b;
      OR: res = bus.rs1 | b;
      XOR: res = bus.rs1 ^ b;
      SLL: res = bus.rs1 << b[4:0];
      SRL: res = bus.rs1 >> b[4:0];
      SRA: res = $signed(bus.rs1) >>> b[4:0];
      SLT: res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.rs1) < $signed(b)};
      SLTU: res = {{(DATA_WIDTH-1){1'b0}}, bus.rs1 < b};
      default: res = '0;
    endcase
  end
  assign idx = res[ADDR_WIDTH+1:2];
  always_ff @(posedge clk)
    if (!rst) begin
      if (!bus.init_done) begin
        if (bus.init_w_enb) mem[bus.init_w_addr] <= bus.init_w_dat;
      end else if (mem_write) mem[idx] <= bus.rs2;
    end
  assign bus.branch = jump | (is_br & br_take);
  assign bus.imm_src = imm_src;
  assign bus.alu_ctrl = alu_ctrl;
  assign bus.alu_src = alu_src;
  assign bus.mem_read = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_2_reg = mem_2_reg;
  assign bus.reg_write = reg_write;
  assign bus.wrt_back_src = wb;
  assign bus.second_u_type_add_src = u_sel;
  assign bus.alu_results = res;
  assign bus.alu_zero = res == '0;
  assign bus.mem_rdata = mem_read ? mem[idx] : '0;
  assign bus.debug_data = mem[bus.debug_addr];
endmodule

// File: tb/tb_rv32i_exec_mem_unit.sv
// tb_rv32i_exec_mem_unit: randomized scoreboard bench for rv32i_exec_mem_unit against an instruction-level reference model
module tb_rv32i_exec_mem_unit;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
    OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  typedef struct {
    logic branch;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic alu_src, mem_read, mem_write, mem_2_reg, reg_write, sel, zero;
    logic [1:0] wb;
    logic [31:0] res, rdata, dbg;
    logic ci, ca, cw, cs, cd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_care = 1'b0;
  logic [31:0] mem_m [1024];
  exp_t q[$];
  int n_vec = 0, n_chk = 0, n_bad = 0;
  rv32i_exec_mem_unit_if bus ();
  rv32i_exec_mem_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [3:0] ctl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd5;
      3'd2: return 4'd8;
      3'd3: return 4'd9;
      3'd4: return 4'd4;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction
  function automatic logic [31:0] calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: return $signed(a) >>> s;
      4'd8: return {31'b0, $signed(a) < $signed(b)};
      4'd9: return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] i, input logic r, input logic [9:0] dbg);
    exp_t e;
    logic [31:0] sum;
    e = '{default: '0};
    e.ci = 1'b1; e.ca = 1'b1; e.cw = 1'b1; e.cs = 1'b0; e.cd = dbg_care;
    e.dbg = mem_m[dbg];
    sum = a + i;
    if (r) begin
      e.res = a + b;
      e.cs = 1'b1;
    end else
      case (op)
        OP_R: begin
          e.alu_ctrl = ctl(f3, f7[5]); e.res = calc(e.alu_ctrl, a, b); e.wb = 2'b01; e.reg_write = 1'b1;
        end
        OP_I: begin
          e.alu_ctrl = ctl(f3, f3 == 3'd5 && f7[5]); e.alu_src = 1'b1; e.res = calc(e.alu_ctrl, a, i);
          e.wb = 2'b01; e.reg_write = 1'b1;
        end
        OP_LOAD: begin
          e.alu_src = 1'b1; e.res = sum; e.rdata = mem_m[sum[11:2]];
          e.mem_read = 1'b1; e.mem_2_reg = 1'b1; e.reg_write = 1'b1; e.wb = 2'b00;
        end
        OP_STORE: begin
          e.imm_src = 3'b001; e.alu_src = 1'b1; e.res = sum; e.mem_write = 1'b1; e.cw = 1'b0;
        end
        OP_BR: begin
          e.imm_src = 3'b010; e.cw = 1'b0;
          case (f3)
            3'b000: begin e.alu_ctrl = 4'd1; e.res = a - b; e.branch = a == b; end
            3'b001: begin e.alu_ctrl = 4'd1; e.res = a - b; e.branch = a != b; end
            3'b100: begin e.alu_ctrl = 4'd8; e.res = calc(4'd8, a, b); e.branch = $signed(a) < $signed(b); end
            3'b101: begin e.alu_ctrl = 4'd8; e.res = calc(4'd8, a, b); e.branch = $signed(a) >= $signed(b); end
            3'b110: begin e.alu_ctrl = 4'd9; e.res = calc(4'd9, a, b); e.branch = a < b; end
            3'b111: begin e.alu_ctrl = 4'd9; e.res = calc(4'd9, a, b); e.branch = a >= b; end
            default: e.ca = 1'b0;
          endcase
        end
        OP_JAL: begin
          e.imm_src = 3'b100; e.branch = 1'b1; e.wb = 2'b10; e.reg_write = 1'b1; e.ca = 1'b0;
        end
        OP_JALR: begin
          e.alu_src = 1'b1; e.res = sum; e.branch = 1'b1; e.wb = 2'b10; e.reg_write = 1'b1;
        end
        OP_LUI, OP_AUIPC: begin
          e.imm_src = 3'b011; e.wb = 2'b11; e.sel = op == OP_LUI; e.cs = 1'b1; e.reg_write = 1'b1; e.ca = 1'b0;
        end
        default: begin
          e.ci = 1'b0; e.ca = 1'b0; e.cw = 1'b0;
        end
      endcase
    e.zero = e.res == 32'h0;
    return e;
  endfunction
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] i, input logic r, input logic idone,
      input logic [9:0] dbg, input logic ie, input logic [9:0] ia, input logic [31:0] idat);
    logic [31:0] sum;
    @(posedge clk);
    #1;
    rst = r;
    bus.opcode = op; bus.func3 = f3; bus.func7 = f7;
    bus.rs1 = a; bus.rs2 = b; bus.imm = i;
    bus.init_done = idone; bus.init_w_enb = ie; bus.init_w_addr = ia; bus.init_w_dat = idat;
    bus.debug_addr = dbg;
    q.push_back(model(op, f3, f7, a, b, i, r, dbg));
    sum = a + i;
    if (!r) begin
      if (!idone) begin
        if (ie) mem_m[ia] = idat;
      end else if (op == OP_STORE) mem_m[sum[11:2]] = b;
    end
  endtask
  task automatic op(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] i, input logic [9:0] dbg);
    issue(o, f3, f7, a, b, i, 1'b0, 1'b1, dbg, 1'b0, 10'd0, 32'h0);
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (vector %0d)", n, act, ex, n_vec);
    end
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      chk("branch", {31'b0, bus.branch}, {31'b0, e.branch});
      chk("mem_read", {31'b0, bus.mem_read}, {31'b0, e.mem_read});
      chk("mem_write", {31'b0, bus.mem_write}, {31'b0, e.mem_write});
      chk("mem_2_reg", {31'b0, bus.mem_2_reg}, {31'b0, e.mem_2_reg});
      chk("reg_write", {31'b0, bus.reg_write}, {31'b0, e.reg_write});
      chk("mem_rdata", bus.mem_rdata, e.rdata);
      if (e.ci) chk("imm_src", {29'b0, bus.imm_src}, {29'b0, e.imm_src});
      if (e.cw) chk("wrt_back_src", {30'b0, bus.wrt_back_src}, {30'b0, e.wb});
      if (e.cs) chk("u_type_sel", {31'b0, bus.second_u_type_add_src}, {31'b0, e.sel});
      if (e.cd) chk("debug_data", bus.debug_data, e.dbg);
      if (e.ca) begin
        chk("alu_ctrl", {28'b0, bus.alu_ctrl}, {28'b0, e.alu_ctrl});
        chk("alu_src", {31'b0, bus.alu_src}, {31'b0, e.alu_src});
        chk("alu_results", bus.alu_results, e.res);
        chk("alu_zero", {31'b0, bus.alu_zero}, {31'b0, e.zero});
      end
    end
  initial begin
    logic [6:0] ops [10];
    logic [6:0] o;
    logic [31:0] a, b;
    logic [9:0] last;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b1111111};
    for (int k = 0; k < 1024; k++) mem_m[k] = 32'h0;
    bus.opcode = 7'h0; bus.func3 = 3'h0; bus.func7 = 7'h0;
    bus.rs1 = 32'h0; bus.rs2 = 32'h0; bus.imm = 32'h0;
    bus.init_done = 1'b0; bus.init_w_enb = 1'b0; bus.init_w_addr = 10'h0; bus.init_w_dat = 32'h0;
    bus.debug_addr = 10'h0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 1024; k++)
      issue(7'h00, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 10'(k), 1'b1, 10'(k), $urandom);
    dbg_care = 1'b1;
    issue(7'h00, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 10'd1, 1'b1, 10'd1, 32'hDEADBEEF);
    issue(OP_STORE, 3'b010, 7'h0, 32'd8, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1, 10'd2, 1'b0, 10'd0, 32'h0);
    issue(OP_STORE, 3'b010, 7'h0, 32'd8, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1, 10'd2, 1'b0, 10'd0, 32'h0);
    op(OP_I, 3'b100, 7'h0, 32'h0F, 32'h0, 32'h05, 10'd2);
    op(OP_I, 3'b111, 7'h0, 32'h0F, 32'h0, 32'h05, 10'd1);
    op(OP_I, 3'b110, 7'h0, 32'h30, 32'h0, 32'h0A, 10'd1);
    op(OP_LOAD, 3'b010, 7'h0, 32'h0, 32'h0, 32'h4, 10'd1);
    op(OP_STORE, 3'b010, 7'h0, 32'd8, 32'h12345678, 32'h0, 10'd2);
    op(OP_LOAD, 3'b010, 7'h0, 32'd8, 32'h0, 32'h0, 10'd2);
    op(OP_BR, 3'b000, 7'h0, 32'd5, 32'd5, 32'h10, 10'd0);
    op(OP_BR, 3'b001, 7'h0, 32'd5, 32'd5, 32'h10, 10'd0);
    op(OP_BR, 3'b100, 7'h0, 32'hFFFFFFFF, 32'd1, 32'h10, 10'd0);
    op(OP_I, 3'b101, 7'h20, 32'h80000000, 32'h0, 32'h404, 10'd0);
    op(OP_I, 3'b000, 7'h20, 32'h7, 32'h0, 32'hFFFFFFFF, 10'd0);
    op(OP_R, 3'b000, 7'h20, 32'h0, 32'h1, 32'h0, 10'd0);
    last = 10'd0;
    for (int k = 0; k < 600; k++) begin
      o = ops[$urandom_range(0, 9)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {27'b0, b[4:0]};
      if (o == OP_STORE) last = a[11:2];
      issue(o, 3'($urandom), 7'($urandom), a, b, $urandom, $urandom_range(0, 19) == 0,
            $urandom_range(0, 15) != 0, $urandom_range(0, 1) ? last : 10'($urandom),
            1'b1, 10'($urandom), $urandom);
    end
    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending expectations, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
